// File: rtl/twofish_key_sched_seq.sv
// Twofish key schedule front end: splits the key into Me/Mo words and computes the
// RS-derived S-box words one key byte per cycle. Optional macro: TWOFISH_KS_ZEROIZE_EN.
module twofish_key_sched_seq #(
  parameter  int MAX_KEY_W = 256,
  localparam int KMAX      = MAX_KEY_W / 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [MAX_KEY_W-1:0]     key,
  input  logic [1:0]               key_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     valid,
  output logic [KMAX-1:0][31:0]    me,
  output logic [KMAX-1:0][31:0]    mo,
  output logic [KMAX-1:0][31:0]    s,
  output logic [2:0]               k_out
);

  localparam int CW = $clog2(MAX_KEY_W / 8);

  localparam logic [0:3][0:7][7:0] RS = {
    8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E,
    8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5,
    8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19,
    8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03
  };

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  r_state, w_next;
  logic [MAX_KEY_W-1:0]    r_key, w_keyMasked;
  logic [CW-1:0]           r_cnt;
  logic [2:0]              r_k, w_kReq;
  logic [KMAX-1:0][31:0]   r_me, r_mo, r_acc;
  logic                    r_valid, r_err;
  logic                    w_legal, w_accept, w_last;
  logic [7:0]              w_byte;
  logic [31:0]             w_contrib;
  logic [CW-4:0]           w_blk;

  // GF(2^8) multiply over the RS field polynomial x^8+x^6+x^3+x^2+1 (0x14D)
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h4D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  always_comb begin
    w_kReq = 3'd0;
    case (key_len)
      2'd0:    w_kReq = 3'd2;
      2'd1:    w_kReq = 3'd3;
      2'd2:    w_kReq = 3'd4;
      default: w_kReq = 3'd0;
    endcase
    w_legal  = (key_len != 2'd3) && (64 * int'(w_kReq) <= MAX_KEY_W);
    w_accept = (r_state == IDLE) && start && w_legal;
    // Bytes beyond the requested length are dropped so unused blocks read zero
    w_keyMasked = '0;
    for (int i = 0; i < MAX_KEY_W / 8; i++)
      if (i < 8 * int'(w_kReq)) w_keyMasked[8*i +: 8] = key[8*i +: 8];
  end

  always_comb begin
    w_last    = (int'(r_cnt) == 8 * int'(r_k) - 1);
    w_blk     = r_cnt[CW-1:3];
    w_byte    = r_key[{r_cnt, 3'b000} +: 8];
    w_contrib = '0;
    for (int r = 0; r < 4; r++)
      w_contrib[8*r +: 8] = gfMul(RS[r][r_cnt[2:0]], w_byte);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_key   <= '0;
      r_cnt   <= '0;
      r_k     <= 3'd0;
      r_me    <= '0;
      r_mo    <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && start && !w_legal;
      if (w_accept) begin
        r_key   <= w_keyMasked;
        r_k     <= w_kReq;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_valid <= 1'b0;
        for (int i = 0; i < KMAX; i++) begin
          r_me[i] <= w_keyMasked[64*i +: 32];
          r_mo[i] <= w_keyMasked[64*i+32 +: 32];
        end
      end else if (r_state == CALC) begin
        r_acc[w_blk] <= r_acc[w_blk] ^ w_contrib;
        r_cnt        <= r_cnt + CW'(1);
        if (w_last) r_valid <= 1'b1;
      end
`ifdef TWOFISH_KS_ZEROIZE_EN
      else if (r_state == DONE) begin
        r_key <= '0;
      end
`endif
    end

`ifdef TWOFISH_KS_ZEROIZE_EN
  assign me = r_valid ? r_me  : '0;
  assign mo = r_valid ? r_mo  : '0;
  assign s  = r_valid ? r_acc : '0;
`else
  assign me = r_me;
  assign mo = r_mo;
  assign s  = r_acc;
`endif

  // k_out is three bits wide so that a 256-bit key can report four blocks
  assign k_out = r_k;
  assign valid = r_valid;
  assign err   = r_err;

endmodule

// File: tb/tb_twofish_key_sched_seq.sv
// Self-checking bench for twofish_key_sched_seq: scoreboard of expected Me/Mo/S words
// from an independent GF model, plus error, disturbance and reset-abort steps.
module tb_twofish_key_sched_seq;

  logic             clk, rst_n, start;
  logic [255:0]     key;
  logic [1:0]       key_len;
  logic             busy, done, err, valid;
  logic [3:0][31:0] me, mo, s;
  logic [2:0]       k_out;

  logic             start128;
  logic [127:0]     key128;
  logic [1:0]       len128;
  logic             busy128, done128, err128, valid128;
  logic [1:0][31:0] me128, mo128, s128;
  logic [2:0]       k128;

  typedef struct {
    logic [3:0][31:0] s;
    logic [3:0][31:0] me;
    logic [3:0][31:0] mo;
    logic [2:0]       k;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0] lastK = 3'd0;

  logic [7:0] rsTab [4][8] = '{
    '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
    '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
    '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
    '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
  };

  twofish_key_sched_seq #(.MAX_KEY_W(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_len(key_len),
    .busy(busy), .done(done), .err(err), .valid(valid),
    .me(me), .mo(mo), .s(s), .k_out(k_out)
  );

  twofish_key_sched_seq #(.MAX_KEY_W(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .key(key128), .key_len(len128),
    .busy(busy128), .done(done128), .err(err128), .valid(valid128),
    .me(me128), .mo(mo128), .s(s128), .k_out(k128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full carry-less product followed by long division by 0x14D
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (prod[i]) prod = prod ^ (15'h14D << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [3:0][31:0] modelS(input logic [255:0] k, input int nb);
    logic [3:0][31:0] acc;
    acc = '0;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 4; r++)
          acc[b][8*r +: 8] = acc[b][8*r +: 8] ^ refMul(rsTab[r][c], k[64*b + 8*c +: 8]);
    return acc;
  endfunction

  function automatic logic [255:0] randKey();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one start pulse; returns #1 after the accepting edge (cycle 1 of the request)
  task automatic applyStimulus(input logic [255:0] k, input logic [1:0] len, input bit expectDone);
    exp_t e;
    int   nb;
    nb = (len == 2'd0) ? 2 : (len == 2'd1) ? 3 : 4;
    e.k   = 3'(nb);
    e.lat = 8 * nb + 1;
    e.s   = modelS(k, nb);
    for (int b = 0; b < 4; b++) begin
      e.me[b] = (b < nb) ? k[64*b +: 32]    : 32'h0;
      e.mo[b] = (b < nb) ? k[64*b+32 +: 32] : 32'h0;
    end
    if (expectDone) begin
      sb.push_back(e);
      lastK = e.k;
    end
    @(posedge clk); #1;
    start = 1'b1; key = k; key_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int cyc0);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, " sbDepth"}, 128'(sb.size()), 128'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput({tag, " latency"}, 128'(cyc), 128'(e.lat));
    checkOutput({tag, " done"}, 128'(done), 128'd1);
    checkOutput({tag, " validAtDone"}, 128'(valid), 128'd1);
    checkOutput({tag, " s"}, s, e.s);
    checkOutput({tag, " me"}, me, e.me);
    checkOutput({tag, " mo"}, mo, e.mo);
    checkOutput({tag, " kOut"}, 128'(k_out), 128'(e.k));
    @(posedge clk); #1;
    checkOutput({tag, " donePulse"}, 128'(done), 128'd0);
    checkOutput({tag, " validHeld"}, 128'(valid), 128'd1);
    checkOutput({tag, " busyAfter"}, 128'(busy), 128'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 128'(busy), 128'd0);
    checkOutput({tag, " done"}, 128'(done), 128'd0);
    checkOutput({tag, " err"}, 128'(err), 128'd0);
    checkOutput({tag, " valid"}, 128'(valid), 128'd0);
    checkOutput({tag, " kOut"}, 128'(k_out), 128'd0);
    checkOutput({tag, " s"}, s, 128'd0);
    checkOutput({tag, " me"}, me, 128'd0);
    checkOutput({tag, " mo"}, mo, 128'd0);
  endtask

  initial begin
    logic [255:0] kv;
    int           donesSeen;
    rst_n = 1'b0; start = 1'b0; key = '0; key_len = 2'd0;
    start128 = 1'b0; key128 = '0; len128 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    applyStimulus(256'd0, 2'd0, 1'b1);
    waitResult("zeroKey", 1);

    kv = 256'h01;
    applyStimulus(kv, 2'd0, 1'b1);
    waitResult("byte0eq1", 1);
    checkOutput("byte0eq1 s0const", 128'(s[0]), 128'hA402A401);

    kv = 256'h0100;
    applyStimulus(kv, 2'd0, 1'b1);
    waitResult("byte1eq1", 1);
    checkOutput("byte1eq1 s0const", 128'(s[0]), 128'h55A156A4);

    kv = 256'h02;
    applyStimulus(kv, 2'd0, 1'b1);
    waitResult("byte0eq2", 1);
    checkOutput("byte0eq2 s0const", 128'(s[0]), 128'h05040502);

    kv = 256'd1 << 192;
    applyStimulus(kv, 2'd2, 1'b1);
    waitResult("byte24", 1);
    checkOutput("byte24 s3const", 128'(s[3]), 128'hA402A401);
    checkOutput("byte24 me3const", 128'(me[3]), 128'h1);

    applyStimulus(randKey(), 2'd1, 1'b1);
    waitResult("rand192", 1);
    applyStimulus(randKey(), 2'd0, 1'b1);
    waitResult("rand128", 1);

    // Illegal length on the wide instance, oversized lengths on the 128-bit one
    @(posedge clk); #1;
    start = 1'b1; key_len = 2'd3; start128 = 1'b1; len128 = 2'd2;
    @(posedge clk); #1;
    start = 1'b0; start128 = 1'b0;
    checkOutput("illegal err", 128'(err), 128'd1);
    checkOutput("illegal busy", 128'(busy), 128'd0);
    checkOutput("illegal valid", 128'(valid), 128'd1);
    checkOutput("illegal kOut", 128'(k_out), 128'(lastK));
    checkOutput("over256 err", 128'(err128), 128'd1);
    checkOutput("over256 busy", 128'(busy128), 128'd0);
    checkOutput("over256 valid", 128'(valid128), 128'd0);
    @(posedge clk); #1;
    checkOutput("illegal errPulse", 128'(err), 128'd0);
    checkOutput("illegal busyLater", 128'(busy), 128'd0);
    start128 = 1'b1; len128 = 2'd1;
    @(posedge clk); #1;
    start128 = 1'b0;
    checkOutput("over192 err", 128'(err128), 128'd1);
    checkOutput("over192 busy", 128'(busy128), 128'd0);

    // Re-pulsed start and key change mid-CALC must not disturb the result
    kv = 256'h01;
    applyStimulus(kv, 2'd0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("midop busy", 128'(busy), 128'd1);
    checkOutput("midop valid", 128'(valid), 128'd0);
`ifdef TWOFISH_KS_ZEROIZE_EN
    checkOutput("midop sHidden", s, 128'd0);
    checkOutput("midop meHidden", me, 128'd0);
`else
    checkOutput("midop sPartial", 128'(s[0]), 128'hA402A401);
    checkOutput("midop meShown", 128'(me[0]), 128'h1);
`endif
    start = 1'b1; key = {256{1'b1}}; key_len = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    waitResult("midop", 6);

    // Reset during CALC aborts the request with no done pulse
    applyStimulus(randKey(), 2'd2, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    checkOutput("abort busyBefore", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    donesSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) donesSeen++;
    end
    checkOutput("abort noDone", 128'(donesSeen), 128'd0);
    checkOutput("abort idle", 128'(busy), 128'd0);

    applyStimulus(randKey(), 2'd2, 1'b1);
    waitResult("afterAbort", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
